uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100000000, meaning the sysclk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, meaning the line bit rate.
REQ-003 The block SHALL have parameter OVERSAMPLE, default 16, meaning the number of sample ticks per bit.
REQ-004 sysclk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset, sampled on the sysclk rising edge.
REQ-006 rx_enable  input  1  when high, new frames are accepted.
REQ-007 PC_Uart_rxd  input  1  asynchronous serial line, 8N1, idle high.
REQ-008 rx_data  output  8  last correctly received byte, LSB first on the line.
REQ-009 rx_status  output  1  one-cycle pulse marking that rx_data has just been updated.
REQ-010 frame_err  output  1  one-cycle pulse marking a frame rejected at the stop bit.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 PC_Uart_rxd SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized value.
REQ-013 A tick generator SHALL pulse for one cycle every DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)) cycles; defaults give DIV = 651.
REQ-014 The tick counter SHALL be ceil(log2(DIV)) bits wide and wrap from DIV-1 to 0.
REQ-015 The tick counter SHALL be cleared to 0 on start-bit detection so that sampling is phase-aligned to the falling edge.
REQ-016 The FSM SHALL have four states: IDLE, START, DATA and STOP.
REQ-017 IDLE->START SHALL occur when rx_enable=1 and a high-to-low transition is seen on the synchronized line; the sample counter SHALL clear on this transition.
REQ-018 In START, at sample 7 the line SHALL be re-checked: if low, go to DATA with the sample and bit counters cleared; if high, treat it as a glitch and return to IDLE with no pulse.
REQ-019 In DATA, each bit SHALL be the majority vote of samples 7, 8 and 9 of its bit period.
REQ-020 Each DATA bit SHALL be shifted in at the MSB of a shift register, so that the LSB is received first.
REQ-021 After the 8th bit, at sample 15, the FSM SHALL go to STOP.
REQ-022 In STOP, at the majority-vote point, if the vote is 1: load rx_data from the shift register, pulse rx_status for exactly one cycle, and go to IDLE.
REQ-023 In STOP, if the vote is 0: leave rx_data unchanged, pulse frame_err for one cycle, and stay in STOP until the line reads high, then go to IDLE.
REQ-024 Latency from the stop-bit sample point to the rx_status pulse SHALL be 1 cycle.
REQ-025 rx_enable falling while busy SHALL abort to IDLE on the next cycle, with no pulse and rx_data unchanged.
REQ-026 A falling edge during the stop-bit window after a valid vote SHALL be detected as a new start in the next IDLE cycle; back-to-back frames SHALL be received with no lost bytes.
REQ-027 rx_status and frame_err SHALL never be high in the same cycle.
REQ-028 rx_data SHALL hold its value until the next valid frame, with no dependence on any reader.

Reset
REQ-029 While reset=0: state=IDLE, both synchronizer flops=1, tick and sample counters=0, shift register=0, rx_data=8'h00, rx_status=0, frame_err=0, busy=0.
REQ-030 A reset asserted mid-frame SHALL discard the partial byte; after release the block SHALL wait for a fresh falling edge.

Structure
REQ-031 The state enum and OVERSAMPLE, SAMPLE_MID=8 and DATA_BITS=8 SHALL live in shared package uart_pkg, to be reused by the transmitter.
REQ-032 The tick generator SHALL be one sub-module, uart_baud_tick, with ports sysclk, reset, clear and tick; the FSM, majority vote and shift register SHALL stay in uart_receiver.

Verification
REQ-033 Drive 8'hA5 at 9600 baud with defaults -> one rx_status pulse, rx_data=8'hA5, frame_err=0.
REQ-034 Drive 8'h3C then 8'hC3 back-to-back with no idle gap -> two rx_status pulses, with rx_data 8'h3C then 8'hC3.
REQ-035 Drive a 3-tick (1953-cycle) low glitch -> no pulses, busy returns to 0, rx_data unchanged.
REQ-036 Drive 8'h55 with the stop bit forced to 0 for 2 bit times -> one frame_err pulse, rx_data unchanged, and IDLE is entered only after the line returns high.
REQ-037 Drop rx_enable at data bit 4 of 8'hFF, then send 8'h12 with rx_enable=1 -> no pulse for the first frame, rx_data=8'h12 after the second.
REQ-038 Pulse reset low for 1 cycle mid-frame of 8'h81 -> all outputs 0, no pulse for the interrupted frame, and a following 8'h7E is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and
// the 2-of-3 majority helper used for bit decisions.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 8;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV sysclk cycles.
// The clear input restarts the count so ticks are phase-aligned to an event.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  // Free-running divider, wrapping at DIV-1; clear and reset force it to 0.
  always_ff @(posedge sysclk) begin
    if (!reset || clear) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 2-flop line synchronizer, oversampled majority
// voting and stop-bit checking.
// Output protocol: rx_status is a valid-only strobe (no ready); it is high for
// exactly one cycle when rx_data has just been loaded, and rx_data then holds
// until the next good frame. frame_err is a one-cycle strobe for a frame whose
// stop bit voted 0; it never coincides with rx_status.
module uart_receiver #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       rx_enable,
  input  logic       PC_Uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_status,
  output logic       frame_err,
  output logic       busy
);

  import uart_pkg::*;

  localparam int DIV = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_V0   = SW'(SAMPLE_MID - 1);
  localparam logic [SW-1:0] S_V1   = SW'(SAMPLE_MID);
  localparam logic [SW-1:0] S_V2   = SW'(SAMPLE_MID + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q, prev_q;
  logic                 rx_s, fall, start_det, tick;
  uart_state_e          state_q;
  logic [SW-1:0]        sample_q, sample_d;
  logic [BW-1:0]        bit_q;
  logic [1:0]           vote_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 stop_fail_q;
  logic [7:0]           rx_data_q;
  logic                 rx_status_q, frame_err_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= PC_Uart_rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_s      = sync2_q;
  assign fall      = prev_q & ~sync2_q;
  assign start_det = (state_q == ST_IDLE) && rx_enable && fall;
  assign sample_d  = (sample_q == S_LAST) ? '0 : sample_q + 1'b1;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .sysclk (sysclk),
    .reset  (reset),
    .clear  (start_det),
    .tick   (tick)
  );

  // Receive FSM: start validation, data voting/shifting, stop check, outputs.
  // A start bit is confirmed at its midpoint and DATA begins at its end, so the
  // vote samples sit at the centre of every following bit.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sample_q    <= '0;
      bit_q       <= '0;
      vote_q      <= '0;
      shift_q     <= '0;
      stop_fail_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_status_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_status_q <= 1'b0;
      frame_err_q <= 1'b0;
      if ((state_q != ST_IDLE) && !rx_enable) begin
        state_q     <= ST_IDLE;
        sample_q    <= '0;
        bit_q       <= '0;
        stop_fail_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_det) begin
              state_q  <= ST_START;
              sample_q <= '0;
            end
          end
          ST_START: begin
            if (tick) begin
              sample_q <= sample_d;
              if ((sample_q == S_V0) && rx_s) begin
                state_q  <= ST_IDLE;
                sample_q <= '0;
              end else if (sample_q == S_LAST) begin
                state_q  <= ST_DATA;
                sample_q <= '0;
                bit_q    <= '0;
              end
            end
          end
          ST_DATA: begin
            if (tick) begin
              sample_q <= sample_d;
              if (sample_q == S_V0) vote_q[0] <= rx_s;
              if (sample_q == S_V1) vote_q[1] <= rx_s;
              if (sample_q == S_V2) begin
                shift_q <= {maj3(vote_q[0], vote_q[1], rx_s), shift_q[DATA_BITS-1:1]};
              end
              if (sample_q == S_LAST) begin
                bit_q <= bit_q + 1'b1;
                if (bit_q == B_LAST) begin
                  state_q <= ST_STOP;
                  bit_q   <= '0;
                end
              end
            end
          end
          ST_STOP: begin
            if (stop_fail_q) begin
              if (rx_s) begin
                state_q     <= ST_IDLE;
                stop_fail_q <= 1'b0;
                sample_q    <= '0;
              end
            end else if (tick) begin
              sample_q <= sample_d;
              if (sample_q == S_V0) vote_q[0] <= rx_s;
              if (sample_q == S_V1) vote_q[1] <= rx_s;
              if (sample_q == S_V2) begin
                if (maj3(vote_q[0], vote_q[1], rx_s)) begin
                  rx_data_q   <= shift_q;
                  rx_status_q <= 1'b1;
                  state_q     <= ST_IDLE;
                  sample_q    <= '0;
                end else begin
                  frame_err_q <= 1'b1;
                  stop_fail_q <= 1'b1;
                end
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_status = rx_status_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: table of clean frames (including back-to-back)
// plus hand-written glitch, framing error, enable-drop and reset sequences.
module tb_uart_receiver;

  localparam int CLK_HZ  = 614400;
  localparam int BAUD    = 9600;
  localparam int OVS     = 16;
  localparam int DIV     = 4;
  localparam int BIT_CYC = DIV * OVS;
  localparam int NVEC    = 10;

  logic       sysclk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_enable = 1'b0;
  logic       PC_Uart_rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       frame_err;
  logic       busy;

  int         n_checks = 0;
  int         n_errors = 0;
  int         fe_cnt = 0;
  int         ok_cnt = 0;
  int         ok_before;
  logic       mon_en = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] sb_exp;
  logic [7:0] last_data;
  logic [7:0] rnd;

  typedef struct {
    logic [7:0] data;
    int         gap_bits;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[NVEC];

  uart_receiver #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVS)
  ) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .rx_enable   (rx_enable),
    .PC_Uart_rxd (PC_Uart_rxd),
    .rx_data     (rx_data),
    .rx_status   (rx_status),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  // Clock
  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int cyc);
    PC_Uart_rxd = v;
    repeat (cyc) @(posedge sysclk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_cyc);
    drive_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CYC);
    drive_bit(stop_v, stop_cyc);
  endtask

  // Scoreboard monitor: every rx_status pops one expected byte.
  always @(negedge sysclk) begin
    if (mon_en) begin
      if (rx_status || frame_err) check("pulse_exclusive", {31'd0, rx_status & frame_err}, 32'd0);
      if (frame_err) fe_cnt++;
      if (rx_status) begin
        ok_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rx_status: rx_data=%02h, expected no pulse", rx_data);
        end else begin
          sb_exp = exp_q.pop_front();
          check("sb_rx_data", {24'd0, rx_data}, {24'd0, sb_exp});
        end
      end
    end
  end

  initial begin
    vecs[0] = '{8'hA5, 2, 8'hA5};
    vecs[1] = '{8'h3C, 0, 8'h3C};
    vecs[2] = '{8'hC3, 2, 8'hC3};
    vecs[3] = '{8'h00, 1, 8'h00};
    vecs[4] = '{8'hFF, 0, 8'hFF};
    vecs[5] = '{8'h01, 1, 8'h01};
    vecs[6] = '{8'h80, 1, 8'h80};
    for (int i = 7; i < NVEC; i++) begin
      rnd = 8'($urandom_range(0, 255));
      vecs[i] = '{rnd, int'($urandom_range(0, 2)), rnd};
    end

    // Reset state
    mon_en = 1'b1;
    repeat (5) @(posedge sysclk);
    @(negedge sysclk);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_status", {31'd0, rx_status}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge sysclk);
    reset = 1'b1;
    rx_enable = 1'b1;
    drive_bit(1'b1, 2 * BIT_CYC);
    last_data = 8'h00;

    // Clean frames, some back-to-back
    for (int i = 0; i < NVEC; i++) begin
      exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, 1'b1, BIT_CYC);
      @(negedge sysclk);
      check($sformatf("vec%0d_rx_data", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_rx});
      last_data = vecs[i].exp_rx;
      drive_bit(1'b1, vecs[i].gap_bits * BIT_CYC);
    end
    drive_bit(1'b1, BIT_CYC);
    @(negedge sysclk);
    check("clean_busy_idle", {31'd0, busy}, 32'd0);
    check("clean_no_frame_err", fe_cnt, 32'd0);

    // Three-tick low glitch
    ok_before = ok_cnt;
    @(posedge sysclk);
    drive_bit(1'b0, 3 * DIV);
    PC_Uart_rxd = 1'b1;
    @(negedge sysclk);
    check("glitch_busy_during", {31'd0, busy}, 32'd1);
    repeat (BIT_CYC) @(posedge sysclk);
    @(negedge sysclk);
    check("glitch_busy_after", {31'd0, busy}, 32'd0);
    check("glitch_rx_data", {24'd0, rx_data}, {24'd0, last_data});
    check("glitch_no_status", ok_cnt, ok_before);
    check("glitch_no_frame_err", fe_cnt, 32'd0);

    // Stop bit held low for two bit times
    send_frame(8'h55, 1'b0, BIT_CYC + BIT_CYC / 2);
    @(negedge sysclk);
    check("ferr_pulse_count", fe_cnt, 32'd1);
    check("ferr_busy_while_low", {31'd0, busy}, 32'd1);
    check("ferr_rx_data", {24'd0, rx_data}, {24'd0, last_data});
    check("ferr_no_status", ok_cnt, ok_before);
    drive_bit(1'b0, BIT_CYC / 2);
    PC_Uart_rxd = 1'b1;
    repeat (6) @(posedge sysclk);
    @(negedge sysclk);
    check("ferr_idle_after_high", {31'd0, busy}, 32'd0);
    drive_bit(1'b1, BIT_CYC);

    // rx_enable dropped during data bit 4 of 8'hFF, then 8'h12
    drive_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, BIT_CYC);
    drive_bit(1'b1, BIT_CYC / 2);
    rx_enable = 1'b0;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    check("en_drop_abort", {31'd0, busy}, 32'd0);
    drive_bit(1'b1, 4 * BIT_CYC + BIT_CYC / 2);
    check("en_drop_no_status", ok_cnt, ok_before);
    check("en_drop_rx_data", {24'd0, rx_data}, {24'd0, last_data});
    rx_enable = 1'b1;
    drive_bit(1'b1, BIT_CYC);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, BIT_CYC);
    @(negedge sysclk);
    check("en_second_rx_data", {24'd0, rx_data}, 32'h12);
    last_data = 8'h12;
    drive_bit(1'b1, BIT_CYC);

    // One-cycle reset during data bit 7 of 8'h81, then 8'h7E
    ok_before = ok_cnt;
    drive_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 7; i++) drive_bit(((i == 0) ? 1'b1 : 1'b0), BIT_CYC);
    drive_bit(1'b1, BIT_CYC / 2);
    reset = 1'b0;
    @(posedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
    check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    check("midrst_rx_status", {31'd0, rx_status}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    last_data = 8'h00;
    drive_bit(1'b1, BIT_CYC / 2 + BIT_CYC);
    drive_bit(1'b1, BIT_CYC);
    check("midrst_no_status", ok_cnt, ok_before);
    check("midrst_rx_data_held", {24'd0, rx_data}, {24'd0, last_data});
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, BIT_CYC);
    @(negedge sysclk);
    check("midrst_next_rx_data", {24'd0, rx_data}, 32'h7E);
    drive_bit(1'b1, BIT_CYC);

    // Drain scoreboard with a bounded wait
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge sysclk);
    @(negedge sysclk);
    check("sb_drained", exp_q.size(), 32'd0);
    check("total_rx_status", ok_cnt, NVEC + 2);
    check("total_frame_err", fe_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
